// File: rtl/mips_register_file.sv
// -----------------------------------------------------------------------------
// mips_register_file
//
// Purpose:
//   32 x 32-bit general-purpose register file for the single-cycle MIPS CPU.
//   - Two combinational read ports feed the ALU operands.
//   - One synchronous write port takes the writeback result.
//   - Register $0 is hard-wired to zero.
//
// Parameters:
//   DATA_WIDTH  width of each register and of the data ports (default 32)
//   ADDR_WIDTH  address width; depth = 2**ADDR_WIDTH (default 5 -> 32 regs)
//
// Ports:
//   clk    in   1           clock; all state updates on its rising edge
//   reset  in   1           synchronous, active-high; clears every register
//   we3    in   1           write enable for port 3
//   a1     in   ADDR_WIDTH  read address, port 1
//   a2     in   ADDR_WIDTH  read address, port 2
//   a3     in   ADDR_WIDTH  write address, port 3
//   wd3    in   DATA_WIDTH  write data, port 3
//   rd1    out  DATA_WIDTH  read data, port 1 (combinational, zero latency)
//   rd2    out  DATA_WIDTH  read data, port 2 (combinational, zero latency)
//
// Notes:
//   - Reads are combinational, so rd1/rd2 are intentionally not registered.
//   - There is no read-during-write bypass: a read of the register being
//     written shows the old value until the clock edge, then the new one.
//   - Reset takes priority over a write in the same cycle.
// -----------------------------------------------------------------------------
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] a1,
  input  logic [ADDR_WIDTH-1:0] a2,
  input  logic [ADDR_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage. Entry 0 is cleared by reset and never written; the read path
  // forces $0 to zero regardless, so $0 reads zero even before first reset.
  logic [DATA_WIDTH-1:0] regs_r [DEPTH];

  logic                  write_ok_s;
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;

  // Forces the hard-wired zero register to read as zero.
  function automatic logic [DATA_WIDTH-1:0] gate_zero_reg(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH-1:0] result;
    if (addr == {ADDR_WIDTH{1'b0}}) begin
      result = {DATA_WIDTH{1'b0}};
    end else begin
      result = data;
    end
    return result;
  endfunction

  // Qualifies the write: writes to $0 are discarded.
  always_comb begin
    write_ok_s = 1'b0;
    if (we3 && (a3 != {ADDR_WIDTH{1'b0}})) begin
      write_ok_s = 1'b1;
    end else begin
      write_ok_s = 1'b0;
    end
  end

  // Register array update: synchronous reset has priority over the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (write_ok_s) begin
      regs_r[a3] <= wd3;
    end
  end

  // Combinational read ports with $0 forced to zero.
  always_comb begin
    rd1_s = gate_zero_reg(a1, regs_r[a1]);
    rd2_s = gate_zero_reg(a2, regs_r[a2]);
  end

  assign rd1 = rd1_s;
  assign rd2 = rd2_s;

endmodule

// File: tb/tb_mips_register_file.sv
// -----------------------------------------------------------------------------
// tb_mips_register_file
//
// Directed plus random self-checking bench for mips_register_file.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled a further time unit later, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_mips_register_file;

  logic        clk;
  logic        reset;
  logic        we3;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int          n_compared;
  int          n_mismatched;
  logic [31:0] model [32];

  mips_register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts a comparison and reports a mismatch.
  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; return 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b0;
    we3   = 1'b0;
    a1    = 5'd0;
    a2    = 5'd0;
    a3    = 5'd0;
    wd3   = 32'h0;

    // $0 reads zero even before the first reset.
    #1;
    check_value("pre_reset_r0_rd1", rd1, 32'h0);

    // 1. Reset, then sweep every address on both ports.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #1;
      check_value("reset_sweep_rd1", rd1, 32'h0);
      check_value("reset_sweep_rd2", rd2, 32'h0);
    end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // 2. Write then read on both ports without another clock.
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1'b0;
    a1 = 5'd5; a2 = 5'd5;
    #1;
    check_value("write_read_rd1", rd1, 32'hDEADBEEF);
    check_value("write_read_rd2", rd2, 32'hDEADBEEF);
    model[5] = 32'hDEADBEEF;

    // 3. Writes to $0 are discarded.
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF;
    tick();
    we3 = 1'b0;
    a1 = 5'd0; a2 = 5'd0;
    #1;
    check_value("r0_immune_rd1", rd1, 32'h0);
    check_value("r0_immune_rd2", rd2, 32'h0);

    // 4. Write disabled leaves the register unchanged.
    we3 = 1'b0; a3 = 5'd7; wd3 = 32'h12345678;
    tick();
    a1 = 5'd7;
    #1;
    check_value("we_off_rd1", rd1, 32'h0);

    // 5. Read-during-write: old value before the edge, new value after.
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h1;
    tick();
    we3 = 1'b0;
    a1 = 5'd9; a2 = 5'd9;
    #1;
    check_value("rdw_setup_rd1", rd1, 32'h1);
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h2;
    #1;
    check_value("rdw_before_rd1", rd1, 32'h1);
    check_value("rdw_before_rd2", rd2, 32'h1);
    tick();
    #1;
    check_value("rdw_after_rd1", rd1, 32'h2);
    check_value("rdw_after_rd2", rd2, 32'h2);
    we3 = 1'b0;

    // 6. Reset beats a simultaneous write, and clears earlier contents.
    reset = 1'b1; we3 = 1'b1; a3 = 5'd3; wd3 = 32'hA5A5A5A5;
    tick();
    reset = 1'b0; we3 = 1'b0;
    a1 = 5'd5; a2 = 5'd3;
    #1;
    check_value("reset_vs_write_rd2", rd2, 32'h0);
    check_value("reset_clears_r5_rd1", rd1, 32'h0);
    a1 = 5'd9;
    #1;
    check_value("reset_clears_r9_rd1", rd1, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Distinct values in two registers read on both ports at once.
    we3 = 1'b1; a3 = 5'd31; wd3 = 32'h8000_0001;
    tick();
    a3 = 5'd1; wd3 = 32'h0000_00FF;
    tick();
    we3 = 1'b0;
    a1 = 5'd31; a2 = 5'd1;
    #1;
    check_value("two_regs_rd1", rd1, 32'h8000_0001);
    check_value("two_regs_rd2", rd2, 32'h0000_00FF);
    model[31] = 32'h8000_0001;
    model[1]  = 32'h0000_00FF;

    // Random run against the reference array model.
    for (int n = 0; n < 300; n++) begin
      we3 = 1'($urandom_range(0, 1));
      a1  = 5'($urandom_range(0, 31));
      a2  = 5'($urandom_range(0, 31));
      a3  = 5'($urandom_range(0, 31));
      wd3 = $urandom;
      #1;
      check_value("rand_rd1", rd1, (a1 == 5'd0) ? 32'h0 : model[a1]);
      check_value("rand_rd2", rd2, (a2 == 5'd0) ? 32'h0 : model[a2]);
      tick();
      if (we3 && (a3 != 5'd0)) model[a3] = wd3;
    end
    we3 = 1'b0;

    // Final sweep of the whole array against the model.
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(i);
      #1;
      check_value("final_rd1", rd1, (i == 0) ? 32'h0 : model[i]);
      check_value("final_rd2", rd2, (i == 0) ? 32'h0 : model[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
